// File: rtl/cpu_tx_fifo.sv
// CPU-bus transmit FIFO: the CPU pushes bytes through a DATA register and a
// valid/ready stream drains them, with status/count/threshold/control registers and an interrupt.
module cpu_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_RESET = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CS,
    input  logic       Rd_Wr,
    input  logic [3:0] Addr,
    input  logic [7:0] DataIn,
    output logic [7:0] DataOut,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_COUNT  = 4'h2;
    localparam logic [3:0] ADDR_THRESH = 4'h3;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    thresh_q, thresh_d;
    logic          ie_q, ie_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          irq_q, irq_d;

    logic       wr_acc, rd_acc;
    logic       full, empty, almost_full;
    logic       push, pop, flush;
    logic [7:0] rd_val;

    assign wr_acc      = CS & ~Rd_Wr;
    assign rd_acc      = CS & Rd_Wr;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    // Compared at 9 bits so a threshold above DEPTH simply never trips.
    assign almost_full = (9'(count_q) >= 9'(thresh_q));

    assign flush = wr_acc && (Addr == ADDR_CTRL) && DataIn[0];
    assign push  = wr_acc && (Addr == ADDR_DATA) && !full;
    assign pop   = out_valid && out_ready;

    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign DataOut   = data_out_q;
    assign irq       = irq_q;

    always_comb begin
        rd_val = 8'h00;
        case (Addr)
            ADDR_STATUS: rd_val = {3'b000, udf_q, ovf_q, almost_full, full, empty};
            ADDR_COUNT:  rd_val = 8'(count_q);
            ADDR_THRESH: rd_val = thresh_q;
            ADDR_CTRL:   rd_val = {7'b0000000, ie_q};
            default:     rd_val = 8'h00;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        thresh_d   = thresh_q;
        ie_d       = ie_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        data_out_d = data_out_q;
        irq_d      = ie_q & (almost_full | ovf_q);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (wr_acc && (Addr == ADDR_DATA) && full) ovf_d = 1'b1;
        if (wr_acc && (Addr == ADDR_THRESH))       thresh_d = DataIn;
        if (wr_acc && (Addr == ADDR_CTRL)) begin
            ie_d = DataIn[2];
            if (DataIn[1]) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
        end

        if (rd_acc) begin
            data_out_d = rd_val;
            if (Addr == ADDR_DATA) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            thresh_q   <= 8'(AF_RESET);
            ie_q       <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            data_out_q <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            thresh_q   <= thresh_d;
            ie_q       <= ie_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
        end
    end

    // Storage has no reset; contents are only observable while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= DataIn;
    end

endmodule

// File: tb/tb_cpu_tx_fifo.sv
// Self-checking bench for cpu_tx_fifo: directed register/stream scenarios plus
// randomized bus and stream traffic compared against a queue-based model every cycle.
module tb_cpu_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int AF_RESET = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       CS = 1'b0;
    logic       Rd_Wr = 1'b0;
    logic [3:0] Addr = 4'h0;
    logic [7:0] DataIn = 8'h00;
    logic [7:0] DataOut;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       irq;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    cpu_tx_fifo #(.DEPTH(DEPTH), .AF_RESET(AF_RESET)) dut (
        .clk(clk), .rst(rst), .CS(CS), .Rd_Wr(Rd_Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a queue, registers are plain variables.
    logic [7:0] m_q[$];
    int         m_thresh = AF_RESET;
    bit         m_ie = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_irq = 1'b0;
    logic [7:0] m_dout = 8'h00;

    function automatic logic [7:0] model_reg(input logic [3:0] a);
        int sz;
        sz = m_q.size();
        case (a)
            4'h1: return {3'b000, m_udf, m_ovf, (sz >= m_thresh), (sz == DEPTH), (sz == 0)};
            4'h2: return 8'(sz);
            4'h3: return 8'(m_thresh);
            4'h4: return {7'b0000000, m_ie};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_thresh = AF_RESET;
            m_ie = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
            m_dout = 8'h00;
        end else begin
            int  sz;
            bit  irq_next, is_wr, is_rd, do_flush;
            sz       = m_q.size();
            irq_next = m_ie && ((sz >= m_thresh) || m_ovf);
            is_wr    = CS && !Rd_Wr;
            is_rd    = CS && Rd_Wr;
            do_flush = is_wr && (Addr == 4'h4) && DataIn[0];
            if (is_rd) m_dout = model_reg(Addr);
            if (sz > 0 && out_ready && !do_flush) void'(m_q.pop_front());
            if (is_wr) begin
                case (Addr)
                    4'h0: if (sz == DEPTH) m_ovf = 1'b1; else m_q.push_back(DataIn);
                    4'h3: m_thresh = int'(DataIn);
                    4'h4: begin
                        if (DataIn[0]) m_q.delete();
                        if (DataIn[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
                        m_ie = DataIn[2];
                    end
                    default: ;
                endcase
            end
            if (is_rd && Addr == 4'h0) m_udf = 1'b1;
            m_irq = irq_next;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every settled cycle the DUT outputs must agree with the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check_output("model out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check_output("model out_data", 32'(out_data), 32'(m_q[0]));
            check_output("model irq", 32'(irq), 32'(m_irq));
            check_output("model DataOut", 32'(DataOut), 32'(m_dout));
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        CS = 1'b1; Rd_Wr = 1'b0; Addr = a; DataIn = d;
        @(negedge clk);
        CS = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a, input logic [7:0] exp);
        CS = 1'b1; Rd_Wr = 1'b1; Addr = a;
        @(negedge clk);
        CS = 1'b0;
        check_output(name, 32'(DataOut), 32'(exp));
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check_output("async rst out_valid", 32'(out_valid), 32'd0);
        check_output("async rst irq", 32'(irq), 32'd0);
        check_output("async rst DataOut", 32'(DataOut), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset irq", 32'(irq), 32'd0);
        bus_read("reset STATUS", 4'h1, 8'h01);
        bus_read("reset COUNT", 4'h2, 8'h00);
        bus_read("reset THRESH", 4'h3, 8'h0C);

        // Three pushes then drain in order
        bus_write(4'h0, 8'hA1);
        bus_write(4'h0, 8'hB2);
        bus_write(4'h0, 8'hC3);
        check_output("push out_valid", 32'(out_valid), 32'd1);
        check_output("push head", 32'(out_data), 32'hA1);
        bus_read("push COUNT", 4'h2, 8'h03);
        out_ready = 1'b1;
        check_output("drain 0", 32'(out_data), 32'hA1);
        @(negedge clk);
        check_output("drain 1", 32'(out_data), 32'hB2);
        @(negedge clk);
        check_output("drain 2", 32'(out_data), 32'hC3);
        @(negedge clk);
        check_output("drain empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Overflow by one write
        for (int i = 0; i < 17; i++) bus_write(4'h0, 8'(i));
        bus_read("ovf STATUS", 4'h1, 8'h0E);
        bus_read("ovf COUNT", 4'h2, 8'h10);
        bus_write(4'h4, 8'h02);
        bus_read("clr STATUS", 4'h1, 8'h06);
        bus_write(4'h4, 8'h01);

        // Interrupt on almost-full
        bus_write(4'h4, 8'h04);
        bus_write(4'h3, 8'h03);
        bus_write(4'h0, 8'h11);
        bus_write(4'h0, 8'h22);
        bus_write(4'h0, 8'h33);
        check_output("irq lag", 32'(irq), 32'd0);
        @(negedge clk);
        check_output("irq set", 32'(irq), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("irq hold", 32'(irq), 32'd1);
        @(negedge clk);
        check_output("irq clear", 32'(irq), 32'd0);
        bus_write(4'h4, 8'h01);

        // Flush with a concurrent pop request
        for (int i = 0; i < 5; i++) bus_write(4'h0, 8'(8'h60 + i));
        out_ready = 1'b1;
        bus_write(4'h4, 8'h01);
        check_output("flush out_valid", 32'(out_valid), 32'd0);
        bus_read("flush COUNT", 4'h2, 8'h00);
        @(negedge clk);
        check_output("flush stays empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Steady push+pop across pointer wrap
        for (int i = 0; i < 4; i++) bus_write(4'h0, 8'(8'h40 + i));
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h0; DataIn = 8'(8'h44 + j);
            check_output("wrap order", 32'(out_data), 32'(8'h40 + j));
            @(negedge clk);
        end
        CS = 1'b0;
        out_ready = 1'b0;
        bus_read("wrap COUNT", 4'h2, 8'h04);

        // Randomized traffic with one asynchronous reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) reset_pulse();
            CS        = ($urandom_range(0, 9) < 7);
            Rd_Wr     = $urandom_range(0, 1);
            Addr      = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            DataIn    = 8'($urandom);
            if (Addr == 4'h3) DataIn = 8'($urandom_range(0, DEPTH + 2));
            if (Addr == 4'h4 && $urandom_range(0, 3) != 0) DataIn[0] = 1'b0;
            out_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        CS = 1'b0;
        out_ready = 1'b0;

        // Zero threshold and DATA-read sticky flag
        reset_pulse();
        bus_write(4'h3, 8'h00);
        bus_read("thresh0 STATUS", 4'h1, 8'h05);
        bus_read("DATA read", 4'h0, 8'h00);
        bus_read("udf STATUS", 4'h1, 8'h15);
        bus_read("CTRL ie", 4'h4, 8'h00);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
